z80_mem_responder: RTL and testbench
====================================

Name: z80_mem_responder

Overview:
- Memory-side bus responder for the Z80 core's external bus; the target end of opcode-fetch, memory-read and memory-write cycles.
- Decodes MREQ_L/RD_L/WR_L/RFSH_L and the address, and inserts a programmable number of wait states via WAIT_L.
- Returns read data from an internal byte RAM and commits write data into it.
- Sits on the same bus as control_logic in system-level benches and FPGA top.

Parameters:
- ADDR_W, 12, RAM depth is 2**ADDR_W bytes; address bits [ADDR_W-1:0] index it.
- BASE_ADDR, 16'h0000, block responds only when addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W].
- WAIT_STATES, 0, WAIT_L low cycles per access, 0..15.

Ports:
- clk  in  1  clock, all sampling on posedge
- rst_L  in  1  asynchronous active-low reset
- addr  in  16  address bus from CPU
- data_in  in  8  write data from CPU
- data_out  out  8  read data to CPU
- data_oe  out  1  1 = responder drives data bus
- MREQ_L  in  1  memory request, active low
- RD_L  in  1  read strobe, active low
- WR_L  in  1  write strobe, active low
- M1_L  in  1  opcode-fetch marker, active low (informational)
- RFSH_L  in  1  refresh marker, active low
- IORQ_L  in  1  I/O request, active low; any cycle with IORQ_L=0 is ignored
- WAIT_L  out  1  wait request to CPU, active low
- rfsh_count  out  8  refresh counter (only with Z80_MEM_RFSH_CNT_EN)

Behaviour:
- Reset (async, rst_L=0): state=IDLE, WAIT_L=1, data_oe=0, data_out=8'h00, wait counter=0. RAM contents are not cleared.
- hit = MREQ_L==0 && RFSH_L==1 && IORQ_L==1 && addr in window && (RD_L ^ WR_L); all terms sampled at posedge.
- RD_L==0 && WR_L==0 together is not a hit; the block stays in IDLE.
- States IDLE, WAIT, ACCESS, HOLD:
  - IDLE: on a hit, latch addr[ADDR_W-1:0] and op (rd = ~RD_L) and load wcnt=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: WAIT_L=0 (decoded from the registered state, glitch-free). Decrement wcnt; go to ACCESS when wcnt==1. WAIT_L is therefore low for exactly WAIT_STATES cycles.
  - ACCESS: for a read, data_out <= mem[latched addr]. For a write, mem[latched addr] <= data_in sampled this edge. Go to HOLD.
  - HOLD: data_oe=1 iff op is read; data_out is held stable. Return to IDLE on the first posedge with MREQ_L==1. data_oe drops in that same transition.
- Read latency, 0 waits: hit at edge E0, data_out valid and data_oe=1 after E1.
- Read latency, N waits: data_out valid and data_oe=1 after edge E0+N+1.
- Abort: MREQ_L==1 sampled in WAIT or ACCESS → IDLE. No RAM write occurs and data_oe stays 0.
- Back-to-back cycles: a new hit is only recognised from IDLE. At least one cycle with MREQ_L==1 must separate accesses.
- Address wrap: only low ADDR_W bits index the RAM. Out-of-window addresses are never hits, and WAIT_L stays 1 for them.
- M1_L does not change timing; fetches follow the read path.
- rst_L asserted mid-access: immediate IDLE, outputs go to their reset values, and any in-flight write is dropped.

Optional Feature:
- Macro: Z80_MEM_RFSH_CNT_EN.
- Defined: port rfsh_count exists and resets to 0. It increments by 1 on each posedge where MREQ_L==0 && RFSH_L==0 and the previous sample was not a refresh (edge-detected, once per refresh cycle). It wraps 255→0.
- Undefined: port and counter logic are absent; refresh cycles are simply ignored.

Decomposition:
- Package z80_mem_pkg: state enum (IDLE, WAIT, ACCESS, HOLD), WAIT_CNT_W=4, default ADDR_W/BASE_ADDR.
- One sub-module, z80_mem_array: synchronous byte RAM with one registered read port and one write port, parameterised by ADDR_W.

Test Plan:
- Write 8'hA5 to 16'h0010 (WAIT_STATES=0), then read 16'h0010 → data_out=8'hA5, data_oe=1 one edge after the ACCESS edge, WAIT_L never low.
- WAIT_STATES=3: read 16'h0020 → WAIT_L low exactly 3 cycles, data_oe rises on the 5th edge after the hit.
- Address 16'h1010 with ADDR_W=12, BASE_ADDR=0 → no response: WAIT_L=1, data_oe=0. Preloaded 16'h0010 is unchanged.
- WAIT_STATES=4: write 8'h3C to 16'h0030, deassert MREQ_L after 2 wait cycles → IDLE, subsequent read returns the prior value.
- Pulse rst_L low during HOLD of a read → data_oe=0, WAIT_L=1, data_out=8'h00 immediately. RAM still holds 8'hA5 at 16'h0010.
- With Z80_MEM_RFSH_CNT_EN: issue 257 refresh cycles (RFSH_L=0, MREQ_L=0, 2 cycles each) → rfsh_count=8'h01, no RAM access or WAIT_L assertion.

Source files
------------

// File: rtl/z80_mem_pkg.sv
// Shared types and defaults for the Z80 memory-side bus responder.
// Optional refresh counter is enabled by Z80_MEM_RFSH_CNT_EN.
package z80_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        HOLD
    } state_t;

    localparam int          WAIT_CNT_W    = 4;
    localparam int          DEF_ADDR_W    = 12;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

endpackage

// File: rtl/z80_mem_array.sv
// Synchronous byte RAM: one write port, one registered read port.
// Only the read register is reset; the storage keeps its contents.
module z80_mem_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rdata_q <= 8'h00;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/z80_mem_responder.sv
// Z80 memory-cycle target with programmable wait states and byte RAM.
// Define Z80_MEM_RFSH_CNT_EN to add the rfsh_count refresh counter port.
import z80_mem_pkg::*;

module z80_mem_responder #(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter logic [15:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        MREQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        M1_L,
    input  logic        RFSH_L,
    input  logic        IORQ_L,
    output logic        WAIT_L
`ifdef Z80_MEM_RFSH_CNT_EN
    ,
    output logic [7:0]  rfsh_count
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

    state_t                  state_q;
    logic [ADDR_W-1:0]       a_q;
    logic                    rd_q;
    logic [WAIT_CNT_W-1:0]   wcnt_q;
    logic                    oe_q;
    logic                    wait_l_q;
    logic                    in_win;
    logic                    hit;
    logic                    mem_we;
    logic                    mem_re;
    logic                    unused_m1;

    // Fetches take the plain read path, so M1_L carries no timing role.
    assign unused_m1 = M1_L;

    assign in_win = addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W];
    assign hit    = !MREQ_L && RFSH_L && IORQ_L && in_win && (RD_L ^ WR_L);
    assign mem_we = (state_q == ACCESS) && !MREQ_L && !rd_q;
    assign mem_re = (state_q == ACCESS) && !MREQ_L && rd_q;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q  <= IDLE;
            a_q      <= '0;
            rd_q     <= 1'b0;
            wcnt_q   <= '0;
            oe_q     <= 1'b0;
            wait_l_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        a_q    <= addr[ADDR_W-1:0];
                        rd_q   <= ~RD_L;
                        wcnt_q <= WS;
                        if (WS != '0) begin
                            state_q  <= WAIT;
                            wait_l_q <= 1'b0;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (MREQ_L) begin
                        state_q  <= IDLE;
                        wait_l_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                        if (wcnt_q == WAIT_CNT_W'(1)) begin
                            state_q  <= ACCESS;
                            wait_l_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (MREQ_L) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= HOLD;
                        oe_q    <= rd_q;
                    end
                end
                HOLD: begin
                    if (MREQ_L) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    oe_q     <= 1'b0;
                    wait_l_q <= 1'b1;
                end
            endcase
        end
    end

    z80_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .rst_n_i (rst_L),
        .we_i    (mem_we),
        .waddr_i (a_q),
        .wdata_i (data_in),
        .re_i    (mem_re),
        .raddr_i (a_q),
        .rdata_o (data_out)
    );

    assign data_oe = oe_q;
    assign WAIT_L  = wait_l_q;

`ifdef Z80_MEM_RFSH_CNT_EN
    logic       rfsh_now;
    logic       rfsh_q;
    logic [7:0] rfsh_cnt_q;

    assign rfsh_now = !MREQ_L && !RFSH_L;

    // Count only the leading edge so a multi-cycle refresh counts once.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            rfsh_q     <= 1'b0;
            rfsh_cnt_q <= 8'h00;
        end else begin
            rfsh_q <= rfsh_now;
            if (rfsh_now && !rfsh_q) rfsh_cnt_q <= rfsh_cnt_q + 8'h01;
        end
    end

    assign rfsh_count = rfsh_cnt_q;
`endif

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench: three responders (0, 3, 4 wait states) on a shared bus.
// Each instance has its own MREQ_L so cycles target one instance at a time.
module tb_z80_mem_responder;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        RD_L, WR_L, M1_L, RFSH_L, IORQ_L;
    logic [2:0]  mreq;
    logic        both_low;
    wire  [2:0]  wl;
    wire  [2:0]  oe;
    wire  [7:0]  dout [3];
`ifdef Z80_MEM_RFSH_CNT_EN
    wire  [7:0]  rc [3];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    z80_mem_responder #(.ADDR_W(12), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_in(data_in),
        .data_out(dout[0]), .data_oe(oe[0]), .MREQ_L(mreq[0]),
        .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L),
        .IORQ_L(IORQ_L), .WAIT_L(wl[0])
`ifdef Z80_MEM_RFSH_CNT_EN
        , .rfsh_count(rc[0])
`endif
    );

    z80_mem_responder #(.ADDR_W(12), .BASE_ADDR(16'h0000), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_in(data_in),
        .data_out(dout[1]), .data_oe(oe[1]), .MREQ_L(mreq[1]),
        .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L),
        .IORQ_L(IORQ_L), .WAIT_L(wl[1])
`ifdef Z80_MEM_RFSH_CNT_EN
        , .rfsh_count(rc[1])
`endif
    );

    z80_mem_responder #(.ADDR_W(12), .BASE_ADDR(16'h0000), .WAIT_STATES(4)) u4 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_in(data_in),
        .data_out(dout[2]), .data_oe(oe[2]), .MREQ_L(mreq[2]),
        .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L),
        .IORQ_L(IORQ_L), .WAIT_L(wl[2])
`ifdef Z80_MEM_RFSH_CNT_EN
        , .rfsh_count(rc[2])
`endif
    );

    // Holds MREQ_L low on instance sel for n edges (edge 1 is the hit edge),
    // recording WAIT_L-low samples and the edge where data_oe first rose.
    task automatic bus_cycle(input int sel, input logic [15:0] a,
                             input logic rd, input logic [7:0] wd,
                             input int n, output int waits,
                             output int oe_edge, output logic [7:0] rdv);
        @(negedge clk);
        addr      = a;
        data_in   = wd;
        RD_L      = ~rd;
        WR_L      = both_low ? 1'b0 : rd;
        mreq[sel] = 1'b0;
        waits     = 0;
        oe_edge   = -1;
        rdv       = 8'h00;
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            if (wl[sel] == 1'b0) waits++;
            if (oe_edge < 0 && oe[sel] == 1'b1) begin
                oe_edge = e;
                rdv     = dout[sel];
            end
        end
        mreq[sel] = 1'b1;
        RD_L      = 1'b1;
        WR_L      = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_L = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (wl[s] !== 1'b1 || oe[s] !== 1'b0 || dout[s] !== 8'h00) begin
                failures++;
                $display("FAIL reset_state[%0d]: got wait_l=%b oe=%b dout=%h want 1 0 00",
                         s, wl[s], oe[s], dout[s]);
            end
`ifdef Z80_MEM_RFSH_CNT_EN
            checks++;
            if (rc[s] !== 8'h00) begin
                failures++;
                $display("FAIL reset_rfsh[%0d]: got %h want 00", s, rc[s]);
            end
`endif
        end
        rst_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ws0;
        int w, e;
        logic [7:0] r;
        bus_cycle(0, 16'h0010, 1'b0, 8'hA5, 3, w, e, r);
        checks++;
        if (w !== 0 || e !== -1) begin
            failures++;
            $display("FAIL ws0_write: got waits=%0d oe_edge=%0d want 0 -1", w, e);
        end
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (w !== 0 || e !== 2 || r !== 8'hA5) begin
            failures++;
            $display("FAIL ws0_read: got waits=%0d oe_edge=%0d data=%h want 0 2 a5", w, e, r);
        end
        checks++;
        if (oe[0] !== 1'b0) begin
            failures++;
            $display("FAIL ws0_release: got oe=%b want 0", oe[0]);
        end
    endtask

    task automatic test_wait_states;
        int w, e;
        logic [7:0] r;
        bus_cycle(1, 16'h0020, 1'b0, 8'h5A, 6, w, e, r);
        checks++;
        if (w !== 3 || e !== -1) begin
            failures++;
            $display("FAIL ws3_write: got waits=%0d oe_edge=%0d want 3 -1", w, e);
        end
        bus_cycle(1, 16'h0020, 1'b1, 8'h00, 7, w, e, r);
        checks++;
        if (w !== 3 || e !== 5 || r !== 8'h5A) begin
            failures++;
            $display("FAIL ws3_read: got waits=%0d oe_edge=%0d data=%h want 3 5 5a", w, e, r);
        end
    endtask

    task automatic test_window;
        int w, e;
        logic [7:0] r;
        bus_cycle(0, 16'h1010, 1'b0, 8'hFF, 3, w, e, r);
        bus_cycle(0, 16'h1010, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (w !== 0 || e !== -1) begin
            failures++;
            $display("FAIL window_miss: got waits=%0d oe_edge=%0d want 0 -1", w, e);
        end
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (e !== 2 || r !== 8'hA5) begin
            failures++;
            $display("FAIL window_alias: got oe_edge=%0d data=%h want 2 a5", e, r);
        end
        bus_cycle(0, 16'h0FFF, 1'b0, 8'hC3, 3, w, e, r);
        bus_cycle(0, 16'h0FFF, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (e !== 2 || r !== 8'hC3) begin
            failures++;
            $display("FAIL window_top: got oe_edge=%0d data=%h want 2 c3", e, r);
        end
    endtask

    task automatic test_ignored;
        int w, e;
        logic [7:0] r;
        IORQ_L = 1'b0;
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        IORQ_L = 1'b1;
        checks++;
        if (w !== 0 || e !== -1) begin
            failures++;
            $display("FAIL iorq_ignored: got waits=%0d oe_edge=%0d want 0 -1", w, e);
        end
        both_low = 1'b1;
        bus_cycle(1, 16'h0020, 1'b1, 8'h00, 6, w, e, r);
        both_low = 1'b0;
        checks++;
        if (w !== 0 || e !== -1) begin
            failures++;
            $display("FAIL rd_wr_both: got waits=%0d oe_edge=%0d want 0 -1", w, e);
        end
        M1_L = 1'b0;
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        M1_L = 1'b1;
        checks++;
        if (w !== 0 || e !== 2 || r !== 8'hA5) begin
            failures++;
            $display("FAIL m1_fetch: got waits=%0d oe_edge=%0d data=%h want 0 2 a5", w, e, r);
        end
    endtask

    task automatic test_abort;
        int w, e;
        logic [7:0] r;
        bus_cycle(2, 16'h0030, 1'b0, 8'h11, 7, w, e, r);
        checks++;
        if (w !== 4 || e !== -1) begin
            failures++;
            $display("FAIL ws4_write: got waits=%0d oe_edge=%0d want 4 -1", w, e);
        end
        bus_cycle(2, 16'h0030, 1'b0, 8'h3C, 2, w, e, r);
        checks++;
        if (w !== 2 || e !== -1 || wl[2] !== 1'b1) begin
            failures++;
            $display("FAIL abort: got waits=%0d oe_edge=%0d wait_l=%b want 2 -1 1",
                     w, e, wl[2]);
        end
        bus_cycle(2, 16'h0030, 1'b1, 8'h00, 8, w, e, r);
        checks++;
        if (w !== 4 || e !== 6 || r !== 8'h11) begin
            failures++;
            $display("FAIL abort_read: got waits=%0d oe_edge=%0d data=%h want 4 6 11", w, e, r);
        end
    endtask

    task automatic test_refresh;
        int bad;
        int w, e;
        logic [7:0] r;
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            addr    = 16'h0010;
            data_in = 8'h77;
            RD_L    = 1'b1;
            WR_L    = 1'b0;
            RFSH_L  = 1'b0;
            mreq[0] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                if (wl[0] !== 1'b1 || oe[0] !== 1'b0) bad++;
            end
            mreq[0] = 1'b1;
            RFSH_L  = 1'b1;
            WR_L    = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL refresh_quiet: got %0d active samples want 0", bad);
        end
`ifdef Z80_MEM_RFSH_CNT_EN
        checks++;
        if (rc[0] !== 8'h01 || rc[1] !== 8'h00) begin
            failures++;
            $display("FAIL rfsh_count: got %h/%h want 01/00", rc[0], rc[1]);
        end
`endif
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (e !== 2 || r !== 8'hA5) begin
            failures++;
            $display("FAIL refresh_ram: got oe_edge=%0d data=%h want 2 a5", e, r);
        end
    endtask

    task automatic test_reset_hold;
        int w, e;
        logic [7:0] r;
        @(negedge clk);
        addr    = 16'h0010;
        RD_L    = 1'b0;
        WR_L    = 1'b1;
        mreq[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (oe[0] !== 1'b1 || dout[0] !== 8'hA5) begin
            failures++;
            $display("FAIL hold_before_reset: got oe=%b data=%h want 1 a5", oe[0], dout[0]);
        end
        #1 rst_L = 1'b0;
        #1;
        checks++;
        if (oe[0] !== 1'b0 || wl[0] !== 1'b1 || dout[0] !== 8'h00) begin
            failures++;
            $display("FAIL reset_in_hold: got oe=%b wait_l=%b data=%h want 0 1 00",
                     oe[0], wl[0], dout[0]);
        end
        @(negedge clk);
        mreq[0] = 1'b1;
        RD_L    = 1'b1;
        rst_L   = 1'b1;
        bus_cycle(0, 16'h0010, 1'b1, 8'h00, 3, w, e, r);
        checks++;
        if (e !== 2 || r !== 8'hA5) begin
            failures++;
            $display("FAIL ram_after_reset: got oe_edge=%0d data=%h want 2 a5", e, r);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_L    = 1'b0;
        addr     = 16'h0000;
        data_in  = 8'h00;
        RD_L     = 1'b1;
        WR_L     = 1'b1;
        M1_L     = 1'b1;
        RFSH_L   = 1'b1;
        IORQ_L   = 1'b1;
        mreq     = 3'b111;
        both_low = 1'b0;
        test_reset();
        test_ws0();
        test_wait_states();
        test_window();
        test_ignored();
        test_abort();
        test_refresh();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
